// File: rtl/alu_control_muldiv_pkg.sv
// ---------------------------------------------------------------------------
// alu_control_muldiv_pkg
//   Shared ALU-control definitions for the multicycle RV32 core: ALU control
//   codes, ALUOp encodings, the RV32M funct7 marker and the M-op funct3 map.
//   The datapath ALU imports the same package, so the codes stay in one place.
// ---------------------------------------------------------------------------
package alu_control_muldiv_pkg;

   // ALU control codes driven to the datapath ALU
   typedef enum logic [3:0] {
      ALU_AND  = 4'd0,
      ALU_OR   = 4'd1,
      ALU_ADD  = 4'd2,
      ALU_XOR  = 4'd3,
      ALU_SLL  = 4'd4,
      ALU_SRL  = 4'd5,
      ALU_SUB  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_code_e;

   // ALUOp from the main control FSM
   typedef enum logic [1:0] {
      ALUOP_MEM    = 2'b00,
      ALUOP_BRANCH = 2'b01,
      ALUOP_RTYPE  = 2'b10,
      ALUOP_ITYPE  = 2'b11
   } aluop_e;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   // RV32M funct3 values
   typedef enum logic [2:0] {
      MOP_MUL    = 3'b000,
      MOP_MULH   = 3'b001,
      MOP_MULHSU = 3'b010,
      MOP_MULHU  = 3'b011,
      MOP_DIV    = 3'b100,
      MOP_DIVU   = 3'b101,
      MOP_REM    = 3'b110,
      MOP_REMU   = 3'b111
   } mop_e;

   // rs1 is treated as signed by MULH, MULHSU, DIV and REM. MUL is left
   // unsigned because the low half of the product is sign-agnostic.
   function automatic logic mop_signed_a(input logic [2:0] f3);
      return (f3 == MOP_MULH) || (f3 == MOP_MULHSU) || (f3 == MOP_DIV) || (f3 == MOP_REM);
   endfunction

   // rs2 is treated as signed by MULH, DIV and REM
   function automatic logic mop_signed_b(input logic [2:0] f3);
      return (f3 == MOP_MULH) || (f3 == MOP_DIV) || (f3 == MOP_REM);
   endfunction

endpackage

// File: rtl/alu_control_muldiv_if.sv
// ---------------------------------------------------------------------------
// alu_control_muldiv_if
//   Bus between the core control/datapath and alu_control_muldiv.
//   master (core):  drives funct7, funct3, alu_op, start, op_a, op_b
//   slave  (block): drives control, is_muldiv, busy, done, result
// ---------------------------------------------------------------------------
interface alu_control_muldiv_if #(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 4
);
   logic [6:0]        funct7;
   logic [2:0]        funct3;
   logic [1:0]        alu_op;
   logic              start;
   logic [XLEN-1:0]   op_a;
   logic [XLEN-1:0]   op_b;
   logic [CTRL_W-1:0] control;
   logic              is_muldiv;
   logic              busy;
   logic              done;
   logic [XLEN-1:0]   result;

   modport master (
      output funct7, funct3, alu_op, start, op_a, op_b,
      input  control, is_muldiv, busy, done, result
   );

   modport slave (
      input  funct7, funct3, alu_op, start, op_a, op_b,
      output control, is_muldiv, busy, done, result
   );
endinterface

// File: rtl/muldiv_iter.sv
// ---------------------------------------------------------------------------
// muldiv_iter
//   Iterative unsigned multiply / restoring divide, one radix-2 step per clock.
//   go         in   load magnitudes and start XLEN steps (counter = XLEN)
//   is_div     in   1 = divide, 0 = multiply (sampled with go)
//   a_mag      in   multiplier / dividend magnitude
//   b_mag      in   multiplicand / divisor magnitude
//   step_done  out  high in the cycle whose edge performs the final step
//   prod       out  2*XLEN-bit product {hi, lo}
//   quot, rem  out  quotient and remainder
// ---------------------------------------------------------------------------
module muldiv_iter #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              go,
   input  logic              is_div,
   input  logic [XLEN-1:0]   a_mag,
   input  logic [XLEN-1:0]   b_mag,
   output logic              step_done,
   output logic [2*XLEN-1:0] prod,
   output logic [XLEN-1:0]   quot,
   output logic [XLEN-1:0]   rem
);

   logic [XLEN-1:0]  hi;       // product high half / partial remainder
   logic [XLEN-1:0]  lo;       // multiplier shifting out / quotient shifting in
   logic [XLEN-1:0]  mcand;    // multiplicand / divisor
   logic [CNT_W-1:0] cnt;
   logic             active;
   logic             div_mode;

   logic [XLEN:0]    mul_sum;
   logic [XLEN:0]    r_shift;
   logic [XLEN:0]    diff;

   always_comb begin
      mul_sum = {1'b0, hi} + ({1'b0, mcand} & {(XLEN+1){lo[0]}});
      r_shift = {hi, lo[XLEN-1]};
      diff    = r_shift - {1'b0, mcand};
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values; blocking here would chain the updates.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi       <= '0;
         lo       <= '0;
         mcand    <= '0;
         cnt      <= '0;
         active   <= 1'b0;
         div_mode <= 1'b0;
      end else if (go) begin
         hi       <= '0;
         lo       <= a_mag;
         mcand    <= b_mag;
         cnt      <= CNT_W'(XLEN);
         active   <= 1'b1;
         div_mode <= is_div;
      end else if (active) begin
         if (div_mode) begin
            // restoring divide: keep the subtraction only if it did not borrow
            if (!diff[XLEN]) begin
               hi <= diff[XLEN-1:0];
               lo <= {lo[XLEN-2:0], 1'b1};
            end else begin
               hi <= r_shift[XLEN-1:0];
               lo <= {lo[XLEN-2:0], 1'b0};
            end
         end else begin
            // shift-add: carry of the add shifts into the product high half
            hi <= mul_sum[XLEN:1];
            lo <= {mul_sum[0], lo[XLEN-1:1]};
         end
         cnt <= cnt - CNT_W'(1);
         if (cnt == CNT_W'(1)) active <= 1'b0;
      end
   end

   assign step_done = active && (cnt == CNT_W'(1));
   assign prod      = {hi, lo};
   assign quot      = lo;
   assign rem       = hi;

endmodule

// File: rtl/alu_control_muldiv.sv
// ---------------------------------------------------------------------------
// alu_control_muldiv
//   ALU control decode for the multicycle RV32 core plus an RV32M engine.
//   clk, reset    rising-edge clock, asynchronous active-high reset
//   bus (slave)   funct7/funct3/alu_op decode inputs, start/op_a/op_b M-op
//                 request; control/is_muldiv (combinational), busy, done
//                 (one-cycle pulse) and result (held until the next op)
//   Holds the decode, the IDLE/CALC/FIX/DONE FSM, divide special cases and
//   the sign fix; the iterative datapath lives in muldiv_iter.
// ---------------------------------------------------------------------------
module alu_control_muldiv
   import alu_control_muldiv_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 4,
   parameter int CNT_W  = 6
) (
   input  logic               clk,
   input  logic               reset,
   alu_control_muldiv_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

   state_e           state, state_nxt;
   alu_code_e        code;
   logic             is_m;

   logic [2:0]       op_q;
   logic             a_neg_q, b_neg_q;

   logic             accept, special, go;
   logic             a_neg, b_neg, div_zero, div_ovf;
   logic [XLEN-1:0]  a_mag, b_mag, special_val, fix_val;
   logic             step_done;
   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0]  quot, rem, quot_s, rem_s;

   // ---------------- decode ----------------
   assign is_m = (bus.alu_op == ALUOP_RTYPE) && (bus.funct7 == FUNCT7_MULDIV);

   // NOTE: code gets a default before the case so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      code = ALU_ADD;
      case (bus.alu_op)
         ALUOP_MEM:    code = ALU_ADD;
         ALUOP_BRANCH: code = ALU_SUB;
         default: begin
            if (!is_m) begin
               case (bus.funct3)
                  3'b000: code = (bus.alu_op == ALUOP_RTYPE && bus.funct7[5]) ? ALU_SUB : ALU_ADD;
                  3'b111: code = ALU_AND;
                  3'b110: code = ALU_OR;
                  3'b100: code = ALU_XOR;
                  3'b001: code = ALU_SLL;
                  3'b101: code = bus.funct7[5] ? ALU_SRA : ALU_SRL;
                  3'b010: code = ALU_SLT;
                  3'b011: code = ALU_SLTU;
                  default: code = ALU_ADD;
               endcase
            end
         end
      endcase
   end

   assign bus.control   = CTRL_W'(code);
   assign bus.is_muldiv = is_m;

   // ---------------- request qualification ----------------
   assign accept = (state == S_IDLE) && bus.start && is_m;

   always_comb begin
      a_neg    = mop_signed_a(bus.funct3) && bus.op_a[XLEN-1];
      b_neg    = mop_signed_b(bus.funct3) && bus.op_b[XLEN-1];
      a_mag    = a_neg ? -bus.op_a : bus.op_a;
      b_mag    = b_neg ? -bus.op_b : bus.op_b;
      div_zero = bus.funct3[2] && (bus.op_b == '0);
      // only signed DIV/REM can overflow: most-negative / -1
      div_ovf  = bus.funct3[2] && !bus.funct3[0]
                 && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);
      special  = div_zero || div_ovf;
      if (div_zero) special_val = bus.funct3[1] ? bus.op_a : '1;
      else          special_val = bus.funct3[1] ? '0 : bus.op_a;
   end

   assign go = accept && !special;

   muldiv_iter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_iter (
      .clk       (clk),
      .reset     (reset),
      .go        (go),
      .is_div    (bus.funct3[2]),
      .a_mag     (a_mag),
      .b_mag     (b_mag),
      .step_done (step_done),
      .prod      (prod),
      .quot      (quot),
      .rem       (rem)
   );

   // ---------------- sign fix ----------------
   always_comb begin
      prod_s = (a_neg_q ^ b_neg_q) ? -prod : prod;
      quot_s = (a_neg_q ^ b_neg_q) ? -quot : quot;
      rem_s  = a_neg_q ? -rem : rem;    // remainder takes the dividend's sign
      case (op_q)
         MOP_MUL:                        fix_val = prod_s[XLEN-1:0];
         MOP_MULH, MOP_MULHSU, MOP_MULHU: fix_val = prod_s[2*XLEN-1:XLEN];
         MOP_DIV, MOP_DIVU:              fix_val = quot_s;
         default:                        fix_val = rem_s;
      endcase
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = special ? S_DONE : S_CALC;
         S_CALC: if (step_done) state_nxt = S_FIX;
         S_FIX:  state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state != S_IDLE);
      bus.done = (state == S_DONE);
   end

   // ---------------- operation registers and result ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q       <= '0;
         a_neg_q    <= 1'b0;
         b_neg_q    <= 1'b0;
         bus.result <= '0;
      end else if (accept) begin
         op_q    <= bus.funct3;
         a_neg_q <= a_neg;
         b_neg_q <= b_neg;
         if (special) bus.result <= special_val;
      end else if (state == S_FIX) begin
         bus.result <= fix_val;
      end
   end

endmodule
